// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers, common to the single- and dual-clock FIFOs.
package fifo_pkg;

    localparam int unsigned FIFO_DWIDTH      = 32;
    localparam int unsigned FIFO_DEPTH       = 16;
    localparam int unsigned FIFO_AMOST_FULL  = 4;
    localparam int unsigned FIFO_AMOST_EMPTY = 4;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DWIDTH x DEPTH register array, one write port, registered or combinational read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = FIFO_DWIDTH,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter bit          REG_RD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DWIDTH-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DWIDTH-1:0]        rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    generate
        if (REG_RD) begin : g_reg_rd
            logic [DWIDTH-1:0] rdata_q;

            // Output register loads on an accepted read and holds otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem_q[raddr];
                end
            end

            assign rdata = rdata_q;
        end else begin : g_comb_rd
            // Read strobe and reset have no role on a combinational read port.
            logic unused_rd;
            assign unused_rd = &{1'b0, rst, re};
            assign rdata     = mem_q[raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost thresholds, flush and sticky errors.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH      = FIFO_DWIDTH,
    parameter int unsigned DEPTH       = FIFO_DEPTH,
    parameter int unsigned AMOST_FULL  = FIFO_AMOST_FULL,
    parameter int unsigned AMOST_EMPTY = FIFO_AMOST_EMPTY
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           write,
    input  logic [DWIDTH-1:0]              din,
    input  logic                           read,
    output logic [DWIDTH-1:0]              dout,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [cnt_width(DEPTH)-1:0]    count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AMOST_FULL);
    localparam logic [CW-1:0] AE_LVL   = CW'(AMOST_EMPTY);

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit REG_RD = 1'b0;
`else
    localparam bit REG_RD = 1'b1;
`endif

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          afull_q,  afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;
    logic          wr_acc,   rd_acc;

    // Acceptance, pointer/count update and next flags from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_acc = write & ~full_q;
            rd_acc = read & ~empty_q;

            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (write & full_q) begin
                ovf_d = 1'b1;
            end
            if (read & empty_q) begin
                udf_d = 1'b1;
            end
        end

        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);
    end

    // State registers; reset overrides flush and any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .REG_RD (REG_RD)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO. It is the synchronous successor of the team's dual-clock FIFO and is used wherever producer and consumer share one clock. It adds an occupancy count, programmable almost thresholds, a synchronous flush, and sticky overflow/underflow error flags. It can also be built in first-word-fall-through (FWFT) mode.

## Interface

Parameters:

- DWIDTH, 32, data width in bits.
- DEPTH, 16, number of entries. Must be a power of two, 2 or more.
- AMOST_FULL, 4, almost_full asserts when count ≥ DEPTH − AMOST_FULL.
- AMOST_EMPTY, 4, almost_empty asserts when count ≤ AMOST_EMPTY.

Ports:

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- write  in  1  push request.
- din  in  DWIDTH  push data.
- read  in  1  pop request.
- dout  out  DWIDTH  pop data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- count  out  $clog2(DEPTH)+1  occupancy, range 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation

- Acceptance: wr_acc = write & !full; rd_acc = read & !empty. Both are evaluated against the registered full/empty flags.
- Pointers:
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally at DEPTH.
  - count is a separate register: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither occur.
- Simultaneous read and write:
  - When full, the read is accepted, the write is dropped, and overflow is set.
  - When empty, the write is accepted, the read is dropped, and underflow is set.
- Flags: full, empty, almost_full and almost_empty are registered and derived from the next-count value, so they are valid in the same cycle as count.
- Sticky errors: overflow and underflow are cleared only by rst. flush does not clear them.
- Priority: rst > flush > read/write.
- flush:
  - Zeroes wr_ptr, rd_ptr and count.
  - Any write or read in the same cycle is ignored and sets no error flag.
  - dout holds its value.
- Memory contents are never reset.
- Standard mode: dout is registered. It is loaded with mem[rd_ptr] on rd_acc and holds its value otherwise.

## Timing

- Reset values: dout=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Standard mode:
  - Read data appears on dout 1 cycle after the read edge.
  - write→empty deassert takes 1 cycle.
  - write→data readable takes 1 cycle.
- FWFT mode: dout = mem[rd_ptr] (combinational from the register array) whenever empty=0. read acknowledges and advances to the next word.
- A reset asserted mid-operation takes effect at the next edge and overrides all in-flight requests.

## Configuration

- SYNC_FIFO_FWFT_EN defined: FWFT behaviour as described above. The output register is removed. dout is undefined-but-stable (last head) while empty.
- SYNC_FIFO_FWFT_EN undefined: standard registered-read mode.

## Structure

- Package fifo_pkg holds:
  - the function computing the count width ($clog2(DEPTH)+1);
  - the default DWIDTH, DEPTH and threshold constants shared with the dual-clock FIFO.
- Sub-module fifo_ram:
  - DWIDTH×DEPTH register array with one write port;
  - read port is registered or combinational, selected by a parameter driven from the macro.
- Pointer, count and flag logic stay in sync_fifo.

## Test plan

All scenarios use DWIDTH=32, DEPTH=16, AMOST_FULL=4, AMOST_EMPTY=4.

- Fill: write 0..15 on consecutive cycles.
  - almost_empty drops at count=5; almost_full rises at count=12.
  - full=1 and count=16 after the 16th write.
  - A 17th write of 0x99 is dropped and overflow=1.
- Drain: 16 consecutive reads.
  - dout = 0..15 in order, each 1 cycle after its read.
  - empty=1 after the last read.
  - An extra read leaves dout=15 and sets underflow=1.
- Wrap-around: write 10 words, read 10, then write 0x100..0x109.
  - Read-back returns 0x100..0x109 in order.
  - count returns to 0.
- Simultaneous read and write:
  - At count=8: count stays 8.
  - At count=16: count becomes 15 and overflow=1.
  - At count=0: count becomes 1 and underflow=1.
- flush with write=1 at count=5:
  - Next cycle: count=0 and empty=1.
  - The written word is not stored.
  - overflow and underflow are unchanged.
- FWFT build: write 0xA5 into an empty FIFO.
  - empty=0 and dout=0xA5 on the next cycle with no read issued.
  - A read then gives empty=1.
